// File: rtl/screen_pkg.sv
// Shared constants and state encoding for the full-screen draw controller.
package screen_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_DRAW_MAP  = 3'd1,
    ST_DRAW_WIN  = 3'd2,
    ST_DRAW_LOSE = 3'd3,
    ST_CLEAR     = 3'd4,
    ST_FINISH    = 3'd5
  } state_t;

  localparam int unsigned PIPE_LAT_DEFAULT = 2;
  localparam int unsigned WDOG_MAX_DEFAULT = 20000;

  localparam int unsigned SCREEN_W = 160;
  localparam int unsigned SCREEN_H = 120;

  localparam int X_W      = 8;
  localparam int Y_W      = 7;
  localparam int COLOUR_W = 9;

endpackage

// File: rtl/screen_draw_controller_if.sv
// VGA adapter write port driven by the draw controller.
interface screen_draw_controller_if
  import screen_pkg::*;
();
  logic [X_W-1:0]      x;
  logic [Y_W-1:0]      y;
  logic [COLOUR_W-1:0] colour;
  logic                plot;

  modport master (output x, output y, output colour, output plot);
  modport slave  (input x, input y, input colour, input plot);
endinterface

// File: rtl/pixel_src_mux.sv
// Selects the pixel stream of the drawer owned by the current state; zero otherwise.
module pixel_src_mux
  import screen_pkg::*;
(
  input  state_t              sel,
  input  logic [X_W-1:0]      map_x,
  input  logic [Y_W-1:0]      map_y,
  input  logic [COLOUR_W-1:0] map_colour,
  input  logic [X_W-1:0]      win_x,
  input  logic [Y_W-1:0]      win_y,
  input  logic [COLOUR_W-1:0] win_colour,
  input  logic [X_W-1:0]      lose_x,
  input  logic [Y_W-1:0]      lose_y,
  input  logic [COLOUR_W-1:0] lose_colour,
  output logic [X_W-1:0]      x,
  output logic [Y_W-1:0]      y,
  output logic [COLOUR_W-1:0] colour
);

  always_comb begin
    x      = '0;
    y      = '0;
    colour = '0;
    case (sel)
      ST_DRAW_MAP: begin
        x      = map_x;
        y      = map_y;
        colour = map_colour;
      end
      ST_DRAW_WIN: begin
        x      = win_x;
        y      = win_y;
        colour = win_colour;
      end
      ST_DRAW_LOSE: begin
        x      = lose_x;
        y      = lose_y;
        colour = lose_colour;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/screen_draw_controller.sv
// Sequences map/win/lose full-screen drawers onto one VGA write port, with a
// per-draw watchdog and a one-cycle drawer clear after every screen.
module screen_draw_controller
  import screen_pkg::*;
#(
  parameter int unsigned PIPE_LAT = PIPE_LAT_DEFAULT,
  parameter int unsigned WDOG_MAX = WDOG_MAX_DEFAULT
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                start_map,
  input  logic                game_won,
  input  logic                game_lost,
  input  logic                map_done,
  input  logic                win_done,
  input  logic                lose_done,
  input  logic [X_W-1:0]      map_x,
  input  logic [Y_W-1:0]      map_y,
  input  logic [COLOUR_W-1:0] map_colour,
  input  logic [X_W-1:0]      win_x,
  input  logic [Y_W-1:0]      win_y,
  input  logic [COLOUR_W-1:0] win_colour,
  input  logic [X_W-1:0]      lose_x,
  input  logic [Y_W-1:0]      lose_y,
  input  logic [COLOUR_W-1:0] lose_colour,
  output logic                map_enable,
  output logic                win_enable,
  output logic                lose_enable,
  output logic                drawer_resetn,
  output logic                busy,
  output logic                screen_done,
  output logic                timeout_err,
  screen_draw_controller_if.master vga
);

  localparam logic [15:0] PIPE_LIM = 16'(PIPE_LAT);
  localparam logic [15:0] WDOG_LIM = 16'(WDOG_MAX);

  state_t              state_reg;
  logic [15:0]         cnt_reg;
  logic [15:0]         cnt_inc;
  logic                plot_arm_reg;
  logic                timeout_reg;
  logic                sel_done;
  logic [X_W-1:0]      mux_x;
  logic [Y_W-1:0]      mux_y;
  logic [COLOUR_W-1:0] mux_colour;

  assign cnt_inc = (cnt_reg == 16'hFFFF) ? cnt_reg : cnt_reg + 16'd1;

  always_comb begin
    sel_done = 1'b0;
    case (state_reg)
      ST_DRAW_MAP:  sel_done = map_done;
      ST_DRAW_WIN:  sel_done = win_done;
      ST_DRAW_LOSE: sel_done = lose_done;
      default:      sel_done = 1'b0;
    endcase
  end

  // plot_arm_reg holds "in DRAW_* with counter past the pipeline latency" for the
  // current cycle, computed one edge early; the live done flag then masks it.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg    <= ST_IDLE;
      cnt_reg      <= '0;
      plot_arm_reg <= 1'b0;
      timeout_reg  <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          plot_arm_reg <= 1'b0;
          if (game_won || game_lost || start_map) begin
            cnt_reg      <= '0;
            timeout_reg  <= 1'b0;
            plot_arm_reg <= (PIPE_LIM == 16'd0);
            if (game_won)
              state_reg <= ST_DRAW_WIN;
            else if (game_lost)
              state_reg <= ST_DRAW_LOSE;
            else
              state_reg <= ST_DRAW_MAP;
          end
        end
        ST_DRAW_MAP, ST_DRAW_WIN, ST_DRAW_LOSE: begin
          if (sel_done) begin
            state_reg    <= ST_CLEAR;
            plot_arm_reg <= 1'b0;
          end else if (cnt_reg >= WDOG_LIM) begin
            state_reg    <= ST_CLEAR;
            plot_arm_reg <= 1'b0;
            timeout_reg  <= 1'b1;
          end else begin
            cnt_reg      <= cnt_inc;
            plot_arm_reg <= (cnt_inc >= PIPE_LIM);
          end
        end
        ST_CLEAR: begin
          state_reg    <= ST_FINISH;
          plot_arm_reg <= 1'b0;
        end
        ST_FINISH: begin
          state_reg    <= ST_IDLE;
          plot_arm_reg <= 1'b0;
        end
        default: begin
          state_reg    <= ST_IDLE;
          plot_arm_reg <= 1'b0;
        end
      endcase
    end
  end

  assign map_enable    = (state_reg == ST_DRAW_MAP);
  assign win_enable    = (state_reg == ST_DRAW_WIN);
  assign lose_enable   = (state_reg == ST_DRAW_LOSE);
  assign busy          = (state_reg != ST_IDLE);
  assign screen_done   = (state_reg == ST_FINISH);
  assign timeout_err   = timeout_reg;
  // Gated with resetn so a reset in the middle of a draw clears the drawers at once.
  assign drawer_resetn = resetn & (state_reg != ST_CLEAR);

  pixel_src_mux u_pixel_src_mux (
    .sel         (state_reg),
    .map_x       (map_x),
    .map_y       (map_y),
    .map_colour  (map_colour),
    .win_x       (win_x),
    .win_y       (win_y),
    .win_colour  (win_colour),
    .lose_x      (lose_x),
    .lose_y      (lose_y),
    .lose_colour (lose_colour),
    .x           (mux_x),
    .y           (mux_y),
    .colour      (mux_colour)
  );

  assign vga.x      = mux_x;
  assign vga.y      = mux_y;
  assign vga.colour = mux_colour;
  assign vga.plot   = plot_arm_reg & ~sel_done;

endmodule

// File: tb/tb_screen_draw_controller.sv
// Directed bench for screen_draw_controller: draws, priority, watchdog, resets.
module tb_screen_draw_controller;
  import screen_pkg::*;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       start_map = 1'b0, game_won = 1'b0, game_lost = 1'b0;
  logic       map_done = 1'b0, win_done = 1'b0, lose_done = 1'b0;
  logic [7:0] map_x = 8'h11, win_x = 8'h22, lose_x = 8'h33;
  logic [6:0] map_y = 7'h05, win_y = 7'h06, lose_y = 7'h07;
  logic [8:0] map_colour = 9'h101, win_colour = 9'h102, lose_colour = 9'h103;
  logic       map_enable, win_enable, lose_enable, drawer_resetn;
  logic       busy, screen_done, timeout_err;

  int compared = 0;
  int mismatched = 0;

  screen_draw_controller_if vga_bus ();

  screen_draw_controller dut (
    .clk (clk), .resetn (resetn),
    .start_map (start_map), .game_won (game_won), .game_lost (game_lost),
    .map_done (map_done), .win_done (win_done), .lose_done (lose_done),
    .map_x (map_x), .map_y (map_y), .map_colour (map_colour),
    .win_x (win_x), .win_y (win_y), .win_colour (win_colour),
    .lose_x (lose_x), .lose_y (lose_y), .lose_colour (lose_colour),
    .map_enable (map_enable), .win_enable (win_enable), .lose_enable (lose_enable),
    .drawer_resetn (drawer_resetn), .busy (busy), .screen_done (screen_done),
    .timeout_err (timeout_err), .vga (vga_bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    #2;
    compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL reset_busy: got %b want 0", busy); end
    compared++; if ({map_enable, win_enable, lose_enable} !== 3'b000) begin mismatched++; $display("FAIL reset_enables: got %b want 000", {map_enable, win_enable, lose_enable}); end
    compared++; if ({screen_done, timeout_err, vga_bus.plot} !== 3'b000) begin mismatched++; $display("FAIL reset_status: got %b want 000", {screen_done, timeout_err, vga_bus.plot}); end
    compared++; if (drawer_resetn !== 1'b0) begin mismatched++; $display("FAIL reset_drawer_resetn: got %b want 0", drawer_resetn); end
    compared++; if (vga_bus.x !== 8'h00) begin mismatched++; $display("FAIL reset_x: got %h want 00", vga_bus.x); end
    tick(); tick();
    resetn = 1'b1;
    tick();
    compared++; if (drawer_resetn !== 1'b1) begin mismatched++; $display("FAIL release_drawer_resetn: got %b want 1", drawer_resetn); end
    compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL release_busy: got %b want 0", busy); end
    $display("test_reset done");
  endtask

  task automatic test_map_draw();
    int first_plot = -1;
    int plot_cnt = 0;
    int en_low = 0;
    int pix_bad = 0;
    map_x = 8'h5A; map_y = 7'h33; map_colour = 9'h1C5;
    start_map = 1'b1;
    tick();
    start_map = 1'b0;
    compared++; if (busy !== 1'b1) begin mismatched++; $display("FAIL map_busy: got %b want 1", busy); end
    for (int c = 0; c <= 19202; c++) begin
      if (c > 0) tick();
      if (c == 19202) begin map_done = 1'b1; #1; end
      if (map_enable !== 1'b1) en_low++;
      if (vga_bus.plot === 1'b1) begin
        plot_cnt++;
        if (first_plot < 0) first_plot = c;
      end
      if (vga_bus.x !== 8'h5A || vga_bus.y !== 7'h33 || vga_bus.colour !== 9'h1C5) pix_bad++;
    end
    compared++; if (en_low !== 0) begin mismatched++; $display("FAIL map_enable_low_cycles: got %0d want 0", en_low); end
    compared++; if (first_plot !== 2) begin mismatched++; $display("FAIL map_first_plot: got %0d want 2", first_plot); end
    compared++; if (plot_cnt !== 19200) begin mismatched++; $display("FAIL map_plot_count: got %0d want 19200", plot_cnt); end
    compared++; if (pix_bad !== 0) begin mismatched++; $display("FAIL map_pixel_mux: got %0d bad cycles want 0", pix_bad); end
    tick();
    map_done = 1'b0;
    compared++; if (drawer_resetn !== 1'b0) begin mismatched++; $display("FAIL map_clear_drawer_resetn: got %b want 0", drawer_resetn); end
    compared++; if ({map_enable, screen_done, vga_bus.plot, busy} !== 4'b0001) begin mismatched++; $display("FAIL map_clear_outputs: got %b want 0001", {map_enable, screen_done, vga_bus.plot, busy}); end
    compared++; if (vga_bus.x !== 8'h00) begin mismatched++; $display("FAIL map_clear_x: got %h want 00", vga_bus.x); end
    tick();
    compared++; if ({screen_done, drawer_resetn, busy} !== 3'b111) begin mismatched++; $display("FAIL map_finish: got %b want 111", {screen_done, drawer_resetn, busy}); end
    tick();
    compared++; if ({screen_done, busy, timeout_err} !== 3'b000) begin mismatched++; $display("FAIL map_idle: got %b want 000", {screen_done, busy, timeout_err}); end
    tick();
    compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL map_no_restart: got %b want 0", busy); end
    $display("test_map_draw done");
  endtask

  task automatic test_priority();
    win_x = 8'hA1; win_y = 7'h4E; win_colour = 9'h0F3;
    game_won = 1'b1; game_lost = 1'b1; start_map = 1'b1;
    tick();
    game_won = 1'b0; game_lost = 1'b0; start_map = 1'b0;
    compared++; if ({map_enable, win_enable, lose_enable} !== 3'b010) begin mismatched++; $display("FAIL prio_enables: got %b want 010", {map_enable, win_enable, lose_enable}); end
    compared++; if ({vga_bus.x, vga_bus.y, vga_bus.colour} !== {8'hA1, 7'h4E, 9'h0F3}) begin mismatched++; $display("FAIL prio_pixel: got %h/%h/%h want a1/4e/0f3", vga_bus.x, vga_bus.y, vga_bus.colour); end
    win_x = 8'h07; win_colour = 9'h1AA;
    #1;
    compared++; if ({vga_bus.x, vga_bus.colour} !== {8'h07, 9'h1AA}) begin mismatched++; $display("FAIL prio_track: got %h/%h want 07/1aa", vga_bus.x, vga_bus.colour); end
    map_done = 1'b1;
    tick();
    map_done = 1'b0;
    compared++; if ({win_enable, drawer_resetn} !== 2'b11) begin mismatched++; $display("FAIL ignore_map_done: got %b want 11", {win_enable, drawer_resetn}); end
    win_done = 1'b1;
    tick();
    win_done = 1'b0;
    compared++; if ({win_enable, drawer_resetn} !== 2'b00) begin mismatched++; $display("FAIL win_clear: got %b want 00", {win_enable, drawer_resetn}); end
    tick(); tick();
    compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL win_idle: got %b want 0", busy); end
    $display("test_priority done");
  endtask

  task automatic test_ignore_request();
    start_map = 1'b1;
    tick();
    start_map = 1'b0;
    game_lost = 1'b1;
    tick();
    game_lost = 1'b0;
    compared++; if ({map_enable, lose_enable} !== 2'b10) begin mismatched++; $display("FAIL ignore_lost_req: got %b want 10", {map_enable, lose_enable}); end
    map_done = 1'b1;
    tick();
    map_done = 1'b0;
    tick(); tick(); tick();
    compared++; if ({busy, lose_enable} !== 2'b00) begin mismatched++; $display("FAIL ignore_not_queued: got %b want 00", {busy, lose_enable}); end
    $display("test_ignore_request done");
  endtask

  task automatic test_back_to_back();
    game_lost = 1'b1;
    tick();
    lose_done = 1'b1;
    tick();
    lose_done = 1'b0;
    tick();
    compared++; if (screen_done !== 1'b1) begin mismatched++; $display("FAIL b2b_finish: got %b want 1", screen_done); end
    tick();
    compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL b2b_idle: got %b want 0", busy); end
    tick();
    compared++; if (lose_enable !== 1'b1) begin mismatched++; $display("FAIL b2b_restart: got %b want 1", lose_enable); end
    game_lost = 1'b0;
    lose_done = 1'b1;
    tick();
    lose_done = 1'b0;
    tick(); tick();
    $display("test_back_to_back done");
  endtask

  task automatic test_watchdog();
    int k = 0;
    start_map = 1'b1;
    tick();
    start_map = 1'b0;
    while (map_enable === 1'b1 && k < 21000) begin
      tick();
      k++;
    end
    compared++; if (k !== 20001) begin mismatched++; $display("FAIL wdog_exit_cycle: got %0d want 20001", k); end
    compared++; if ({drawer_resetn, timeout_err, screen_done} !== 3'b010) begin mismatched++; $display("FAIL wdog_clear: got %b want 010", {drawer_resetn, timeout_err, screen_done}); end
    tick();
    compared++; if ({screen_done, timeout_err} !== 2'b11) begin mismatched++; $display("FAIL wdog_finish: got %b want 11", {screen_done, timeout_err}); end
    tick(); tick();
    compared++; if ({busy, timeout_err} !== 2'b01) begin mismatched++; $display("FAIL wdog_sticky: got %b want 01", {busy, timeout_err}); end
    game_won = 1'b1;
    tick();
    game_won = 1'b0;
    compared++; if ({win_enable, timeout_err} !== 2'b10) begin mismatched++; $display("FAIL wdog_cleared_on_entry: got %b want 10", {win_enable, timeout_err}); end
    win_done = 1'b1;
    tick();
    win_done = 1'b0;
    tick(); tick();
    $display("test_watchdog done");
  endtask

  task automatic test_simultaneous();
    game_won = 1'b1;
    tick();
    game_won = 1'b0;
    for (int k = 1; k <= 20000; k++) tick();
    win_done = 1'b1;
    #1;
    compared++; if (win_enable !== 1'b1) begin mismatched++; $display("FAIL simul_still_drawing: got %b want 1", win_enable); end
    tick();
    win_done = 1'b0;
    compared++; if ({win_enable, drawer_resetn, timeout_err} !== 3'b000) begin mismatched++; $display("FAIL simul_done_wins: got %b want 000", {win_enable, drawer_resetn, timeout_err}); end
    tick(); tick();
    compared++; if ({busy, timeout_err} !== 2'b00) begin mismatched++; $display("FAIL simul_idle: got %b want 00", {busy, timeout_err}); end
    $display("test_simultaneous done");
  endtask

  task automatic test_reset_mid_draw();
    int idle_bad = 0;
    lose_x = 8'h9C; lose_y = 7'h21; lose_colour = 9'h0AB;
    game_lost = 1'b1;
    tick();
    game_lost = 1'b0;
    for (int k = 1; k <= 5000; k++) tick();
    compared++; if ({lose_enable, vga_bus.plot, vga_bus.x} !== {2'b11, 8'h9C}) begin mismatched++; $display("FAIL rst_mid_before: got %b/%b/%h want 1/1/9c", lose_enable, vga_bus.plot, vga_bus.x); end
    resetn = 1'b0;
    #1;
    compared++; if ({lose_enable, busy, vga_bus.plot, drawer_resetn} !== 4'b0000) begin mismatched++; $display("FAIL rst_mid_outputs: got %b want 0000", {lose_enable, busy, vga_bus.plot, drawer_resetn}); end
    compared++; if ({vga_bus.x, vga_bus.y, vga_bus.colour} !== 24'h0) begin mismatched++; $display("FAIL rst_mid_pixel: got %h/%h/%h want 0/0/0", vga_bus.x, vga_bus.y, vga_bus.colour); end
    tick(); tick();
    resetn = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (busy !== 1'b0 || vga_bus.plot !== 1'b0 || lose_enable !== 1'b0) idle_bad++;
    end
    compared++; if (idle_bad !== 0) begin mismatched++; $display("FAIL rst_release_idle: got %0d active cycles want 0", idle_bad); end
    game_lost = 1'b1;
    tick();
    game_lost = 1'b0;
    compared++; if (lose_enable !== 1'b1) begin mismatched++; $display("FAIL rst_fresh_request: got %b want 1", lose_enable); end
    lose_done = 1'b1;
    tick();
    lose_done = 1'b0;
    tick(); tick();
    $display("test_reset_mid_draw done");
  endtask

  initial begin
    test_reset();
    test_map_draw();
    test_priority();
    test_ignore_request();
    test_back_to_back();
    test_watchdog();
    test_simultaneous();
    test_reset_mid_draw();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/screen_draw_controller.md
SCREEN_DRAW_CONTROLLER -- requirements
Module: screen_draw_controller

Interface
REQ-001 SHALL have port clk, input, 1, system clock; all state changes on its rising edge.
REQ-002 SHALL have port resetn, input, 1, reset; asynchronous and active-low.
REQ-003 SHALL have ports start_map, game_won, game_lost, input, 1 each, screen requests; level-sampled.
REQ-004 SHALL have ports map_done, win_done, lose_done, input, 1 each, completion flags from the three full-screen drawers.
REQ-005 SHALL have ports map_x/win_x/lose_x (input, 8), map_y/win_y/lose_y (input, 7) and map_colour/win_colour/lose_colour (input, 9), pixel streams from the drawers.
REQ-006 SHALL have ports map_enable, win_enable, lose_enable, output, 1 each, drawer run enables.
REQ-007 SHALL have port drawer_resetn, output, 1, active-low clear to all drawers.
REQ-008 SHALL have ports x (output, 8), y (output, 7), colour (output, 9) and plot (output, 1), VGA adapter write port.
REQ-009 SHALL have ports busy, screen_done and timeout_err, output, 1 each, status.
REQ-010 SHALL have parameter PIPE_LAT, default 2, cycles from enable rise to first valid drawer pixel.
REQ-011 SHALL have parameter WDOG_MAX, default 20000, watchdog limit in cycles.

Function
REQ-012 SHALL implement states IDLE, DRAW_MAP, DRAW_WIN, DRAW_LOSE, CLEAR and FINISH.
REQ-013 In IDLE, request priority SHALL be game_won > game_lost > start_map; the winner moves the FSM to DRAW_WIN, DRAW_LOSE or DRAW_MAP on the next edge.
REQ-014 In each DRAW_* state, exactly the matching enable SHALL be 1; in all other states every enable SHALL be 0.
REQ-015 While in a DRAW_* state, new requests SHALL be ignored, not queued.
REQ-016 In DRAW_*, the matching done=1 SHALL move the FSM to CLEAR; other done inputs SHALL be ignored.
REQ-017 In CLEAR, drawer_resetn SHALL be 0 for exactly one cycle; it SHALL be 1 in all other states.
REQ-018 CLEAR SHALL always advance to FINISH; FINISH SHALL last one cycle with screen_done=1, then go to IDLE.
REQ-019 busy SHALL be 1 in every state except IDLE.
REQ-020 A 16-bit cycle counter SHALL clear on DRAW_* entry and increment each DRAW_* cycle, saturating at 16'hFFFF.
REQ-021 plot SHALL be registered and SHALL be 1 only when state is DRAW_*, counter >= PIPE_LAT and the matching done is 0.
REQ-022 x, y and colour SHALL be combinationally muxed from the drawer selected by the current state, and SHALL be zero in non-DRAW states.
REQ-023 If the counter reaches WDOG_MAX in DRAW_*, the FSM SHALL go to CLEAR and set timeout_err.
REQ-024 timeout_err SHALL stay 1 until the next DRAW_* entry clears it.
REQ-025 Done and watchdog in the same cycle SHALL be treated as done; timeout_err SHALL stay 0.
REQ-026 A returned-to-IDLE FSM with a request still held SHALL start that screen again (level semantics); the requester drops it after screen_done.

Reset
REQ-027 On resetn=0, the FSM SHALL asynchronously go to IDLE, the counter to 0, and every output to 0, except drawer_resetn.
REQ-028 drawer_resetn SHALL follow resetn combinationally while resetn=0, so reset mid-draw clears the drawers.
REQ-029 Drawing SHALL resume only on a fresh request sampled after reset release.

Structure
REQ-030 State encodings, PIPE_LAT, WDOG_MAX and the screen size constants 160x120 SHALL live in a shared package (screen_pkg).
REQ-031 The 3-way pixel mux SHALL be one sub-module, pixel_src_mux; the FSM, counter and plot register stay in the top.

Verification
REQ-032 Map draw: start_map=1; map_done rises 19202 cycles after map_enable -> map_enable 1 throughout, plot first 1 at enable+2, drawer_resetn low 1 cycle, screen_done one pulse.
REQ-033 Priority: game_won=game_lost=start_map=1 in IDLE -> DRAW_WIN entered; x/y/colour track the win_* inputs.
REQ-034 Watchdog: start_map with map_done held 0 -> CLEAR at counter 20000, timeout_err=1, screen_done pulse; the next request clears timeout_err.
REQ-035 Reset mid-draw: resetn=0 at counter 5000 of DRAW_LOSE -> all outputs 0 and drawer_resetn 0 immediately; nothing drawn after release until a request.
REQ-036 Ignore: game_lost pulsed during DRAW_MAP and map_done pulsed during DRAW_WIN -> no state change.
REQ-037 Simultaneous: win_done=1 on the cycle the counter hits WDOG_MAX -> CLEAR with timeout_err=0.
